// File: rtl/conv_row_scheduler.sv
// conv_row_scheduler: fetches image rows, issues 3-row windows to the conv core and writes each result row back
module conv_row_scheduler #(
    parameter int ROWS   = 128,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] win_row0,
    output logic [DATA_W-1:0] win_row1,
    output logic [DATA_W-1:0] win_row2,
    output logic              win_valid,
    input  logic              conv_valid,
    input  logic [DATA_W-1:0] conv_data,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);
    // pointers carry one extra bit so they can hold ROWS itself when ROWS == 2**ADDR_W
    localparam int PW = ADDR_W + 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [1:0]    fill, fill_inc;
    logic [LW-1:0] lat_cnt;
    logic          cap_last, launch;

    assign fill_inc = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
    assign cap_last = (state == CAPTURE) && (lat_cnt == LW'(RD_LAT - 1));
    assign launch   = ((state == IDLE) || (state == DONE)) && start;

    // next state and state-decoded strobes
    always_comb begin
        state_nx  = state;
        in_rd_en  = 1'b0;
        in_addr   = '0;
        win_valid = 1'b0;
        out_we    = 1'b0;
        out_addr  = '0;
        case (state)
            IDLE, DONE: state_nx = start ? FETCH : state;
            FETCH: begin
                in_rd_en = rd_ptr < PW'(ROWS);
                in_addr  = rd_ptr[ADDR_W-1:0];
                state_nx = CAPTURE;
            end
            CAPTURE: state_nx = !cap_last ? CAPTURE : (fill_inc == 2'd3) ? ISSUE : FETCH;
            ISSUE: begin
                win_valid = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: state_nx = conv_valid ? WRITE : WAIT;
            WRITE: begin
                out_we   = 1'b1;
                out_addr = wr_ptr[ADDR_W-1:0];
                state_nx = (wr_ptr == PW'(ROWS - 3)) ? DONE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end

    // read/write pointers, window fill level and read-latency counter
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            fill    <= '0;
            lat_cnt <= '0;
        end else begin
            if (state == CAPTURE) lat_cnt <= cap_last ? '0 : lat_cnt + LW'(1);
            if (cap_last) begin
                rd_ptr <= rd_ptr + PW'(1);
                fill   <= fill_inc;
            end
            if (state == WRITE) wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // sliding window shift on each captured row, and result latch in WAIT
    always_ff @(posedge clk) begin
        if (reset) begin
            win_row0 <= '0;
            win_row1 <= '0;
            win_row2 <= '0;
            out_data <= '0;
        end else begin
            if (cap_last) begin
                win_row0 <= win_row1;
                win_row1 <= win_row2;
                win_row2 <= in_data;
            end
            if ((state == WAIT) && conv_valid) out_data <= conv_data;
        end
    end
endmodule

// File: tb/tb_conv_row_scheduler.sv
// tb_conv_row_scheduler: table-driven timing plus randomized scoreboard checks of the row scheduler
module tb_conv_row_scheduler;
    localparam int ROWS = 128;
    localparam int AW   = 8;
    localparam int DW   = 1024;
    localparam logic [DW-1:0] S_RES = {32{32'h5A5A_0001}};

    typedef struct {
        bit rd;
        int ra;
        bit wv;
        bit we;
        int wa;
        bit bz;
        bit dn;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, s_start = 1'b0;
    always #5 clk = ~clk;

    logic          in_rd_en, win_valid, out_we, busy, done, conv_valid = 1'b0;
    logic [AW-1:0] in_addr, out_addr;
    logic [DW-1:0] in_data = '0, conv_data = '0, win_row0, win_row1, win_row2, out_data;

    logic          s_rd_en, s_wv, s_we, s_busy, s_done;
    logic [1:0]    s_in_addr, s_out_addr;
    logic [DW-1:0] s_in_data = '0, s_p1 = '0, s_r0, s_r1, s_r2, s_out_data;

    conv_row_scheduler dut (
        .clk(clk), .reset(reset), .start(start),
        .in_rd_en(in_rd_en), .in_addr(in_addr), .in_data(in_data),
        .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2), .win_valid(win_valid),
        .conv_valid(conv_valid), .conv_data(conv_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done)
    );

    conv_row_scheduler #(.ROWS(3), .ADDR_W(2), .DATA_W(DW), .RD_LAT(2)) dut_s (
        .clk(clk), .reset(reset), .start(s_start),
        .in_rd_en(s_rd_en), .in_addr(s_in_addr), .in_data(s_in_data),
        .win_row0(s_r0), .win_row1(s_r1), .win_row2(s_r2), .win_valid(s_wv),
        .conv_valid(1'b1), .conv_data(S_RES),
        .out_we(s_we), .out_addr(s_out_addr), .out_data(s_out_data),
        .busy(s_busy), .done(s_done)
    );

    int tests = 0, fails = 0;
    logic [DW-1:0] mem [ROWS];
    logic [DW-1:0] exp_q [$];
    vec_t tab_d [15];
    vec_t tab_s [14];
    int rd_n = 0, win_n = 0, wr_n = 0;
    bit mon_on = 0, hold_conv = 0, spur_en = 0, pend = 0;
    int dly_min = 0, dly_max = 0, cnt = 0;

    function automatic logic [DW-1:0] rep(input int k);
        return {32{32'(k)}};
    endfunction

    function automatic logic [DW-1:0] rand_row();
        logic [DW-1:0] r;
        for (int j = 0; j < 32; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", n, got, exp);
        end
    endtask

    task automatic chk_w(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h expected=%h (low 64 bits)", n, got[63:0], exp[63:0]);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // input image RAM models: latency 1 for the main instance, 2 for the small one
    always @(posedge clk) if (in_rd_en) in_data <= mem[in_addr];
    always @(posedge clk) begin
        s_p1      <= s_rd_en ? rep(int'(s_in_addr) + 7) : '0;
        s_in_data <= s_p1;
    end

    // conv core model: answers each window after a random WAIT delay, sprays ignored pulses elsewhere
    initial forever begin
        @(posedge clk);
        #2;
        conv_valid = 1'b0;
        conv_data  = rand_row();
        if (win_valid && !hold_conv) begin
            pend       = 1;
            cnt        = $urandom_range(dly_max, dly_min);
            conv_valid = spur_en && ($urandom_range(1, 0) == 1);
        end else if (pend) begin
            if (cnt == 0) begin
                conv_valid = 1'b1;
                exp_q.push_back(conv_data);
                pend = 0;
            end else cnt--;
        end else conv_valid = spur_en && !hold_conv && ($urandom_range(2, 0) == 0);
    end

    // scoreboard: reads sequential, windows = rows m..m+2, one write per window with the WAIT result
    always @(negedge clk) if (mon_on && !reset) begin
        chk("strobe_excl", 64'(int'(in_rd_en) + int'(win_valid) + int'(out_we) <= 1), 1);
        if (!busy) chk("idle_quiet", {in_rd_en, win_valid, out_we}, 0);
        if (in_rd_en) begin
            chk("rd_addr", in_addr, rd_n);
            rd_n++;
        end
        if (win_valid) begin
            chk_w("win_row0", win_row0, mem[win_n % ROWS]);
            chk_w("win_row1", win_row1, mem[(win_n + 1) % ROWS]);
            chk_w("win_row2", win_row2, mem[(win_n + 2) % ROWS]);
            win_n++;
        end
        if (out_we) begin
            chk("wr_addr", out_addr, wr_n);
            chk("we_per_win", wr_n + 1, win_n);
            if (exp_q.size() == 0) chk("wr_result_avail", exp_q.size(), 1);
            else chk_w("wr_data", out_data, exp_q.pop_front());
            chk_w("hold_row0", win_row0, mem[wr_n % ROWS]);
            chk_w("hold_row2", win_row2, mem[(wr_n + 2) % ROWS]);
            wr_n++;
        end
    end

    task automatic begin_pass();
        rd_n = 0;
        win_n = 0;
        wr_n = 0;
        exp_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int c = 0;
        while (!done && c < lim) begin
            tick();
            c++;
        end
        chk("done_within_budget", done, 1);
    endtask

    task automatic end_checks();
        chk("reads_per_pass", rd_n, ROWS);
        chk("windows_per_pass", win_n, ROWS - 2);
        chk("writes_per_pass", wr_n, ROWS - 2);
        chk("busy_after_pass", busy, 0);
        chk("done_after_pass", done, 1);
    endtask

    task automatic chk_reset_state();
        chk("rst_strobes", {in_rd_en, win_valid, out_we, busy, done}, 0);
        chk("rst_addrs", {in_addr, out_addr}, 0);
        chk_w("rst_row0", win_row0, '0);
        chk_w("rst_row1", win_row1, '0);
        chk_w("rst_row2", win_row2, '0);
        chk_w("rst_out_data", out_data, '0);
    endtask

    task automatic run_table(input bit sel, input int n);
        vec_t v;
        logic o_rd, o_wv, o_we, o_bz, o_dn;
        int o_ra, o_wa;
        for (int i = 0; i < n; i++) begin
            if (sel) begin
                v = tab_s[i];
                s_start = (i == 0);
                {o_rd, o_wv, o_we, o_bz, o_dn} = {s_rd_en, s_wv, s_we, s_busy, s_done};
                o_ra = int'(s_in_addr);
                o_wa = int'(s_out_addr);
                if (v.wv) begin
                    chk_w("s_win_row0", s_r0, rep(7));
                    chk_w("s_win_row1", s_r1, rep(8));
                    chk_w("s_win_row2", s_r2, rep(9));
                end
                if (v.we) chk_w("s_out_data", s_out_data, S_RES);
            end else begin
                v = tab_d[i];
                start = (i == 0);
                {o_rd, o_wv, o_we, o_bz, o_dn} = {in_rd_en, win_valid, out_we, busy, done};
                o_ra = int'(in_addr);
                o_wa = int'(out_addr);
            end
            chk($sformatf("t%0d_c%0d_rd_en", sel, i), o_rd, v.rd);
            chk($sformatf("t%0d_c%0d_in_addr", sel, i), o_ra, v.ra);
            chk($sformatf("t%0d_c%0d_win_valid", sel, i), o_wv, v.wv);
            chk($sformatf("t%0d_c%0d_out_we", sel, i), o_we, v.we);
            chk($sformatf("t%0d_c%0d_out_addr", sel, i), o_wa, v.wa);
            chk($sformatf("t%0d_c%0d_busy", sel, i), o_bz, v.bz);
            chk($sformatf("t%0d_c%0d_done", sel, i), o_dn, v.dn);
            tick();
        end
        start = 1'b0;
        s_start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        tab_d = '{'{0,0,0,0,0,0,0}, '{1,0,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{1,1,0,0,0,1,0},
                  '{0,0,0,0,0,1,0}, '{1,2,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,1,0,0,1,0},
                  '{0,0,0,0,0,1,0}, '{0,0,0,1,0,1,0}, '{1,3,0,0,0,1,0}, '{0,0,0,0,0,1,0},
                  '{0,0,1,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,0,1,1,1,0}};
        tab_s = '{'{0,0,0,0,0,0,0}, '{1,0,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,0,0,0,1,0},
                  '{1,1,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{1,2,0,0,0,1,0},
                  '{0,0,0,0,0,1,0}, '{0,0,0,0,0,1,0}, '{0,0,1,0,0,1,0}, '{0,0,0,0,0,1,0},
                  '{0,0,0,1,0,1,0}, '{0,0,0,0,0,0,1}};
        for (int k = 0; k < ROWS; k++) mem[k] = rep(k);
        tick(3);
        chk_reset_state();
        chk("s_rst_strobes", {s_rd_en, s_wv, s_we, s_busy, s_done}, 0);
        reset = 1'b0;
        tick();
        mon_on = 1;

        // first-pass timing against the cycle table, rows = index, immediate results
        rd_n = 0; win_n = 0; wr_n = 0;
        run_table(0, 15);
        wait_done(5000);
        end_checks();

        // fixed 10-cycle result delay with spurious conv_valid pulses on random rows
        for (int k = 0; k < ROWS; k++) mem[k] = rand_row();
        dly_min = 10; dly_max = 10; spur_en = 1;
        begin_pass();
        wait_done(5000);
        end_checks();

        // start while busy is ignored; start after done restarts cleanly
        for (int k = 0; k < ROWS; k++) mem[k] = rand_row();
        dly_min = 0; dly_max = 6;
        begin_pass();
        tick(50);
        start = 1'b1; tick(); start = 1'b0;
        tick(100);
        start = 1'b1; tick(); start = 1'b0;
        wait_done(5000);
        end_checks();
        tick(3);
        chk("done_sticky", done, 1);
        begin_pass();
        chk("restart_done_clear", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_first_read", {in_rd_en, in_addr}, {1'b1, 8'd0});
        wait_done(5000);
        end_checks();

        // reset during WAIT of window 40 aborts, then a fresh full pass
        dly_min = 0; dly_max = 0; spur_en = 0;
        begin_pass();
        c = 0;
        while (win_n < 40 && c < 2000) begin tick(); c++; end
        hold_conv = 1;
        while (win_n < 41 && c < 2000) begin tick(); c++; end
        chk("reached_window_40", win_n, 41);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pend = 0;
        chk_reset_state();
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_we || in_rd_en || win_valid) c++;
            tick();
        end
        chk("no_activity_after_abort", c, 0);
        hold_conv = 0;
        begin_pass();
        wait_done(5000);
        end_checks();

        // ROWS=3, RD_LAT=2 instance
        run_table(1, 14);
        tick(2);
        chk("s_done_sticky", {s_done, s_busy}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_row_scheduler.md
Name: conv_row_scheduler

Overview:
- Sequences one image pass through the row convolution datapath.
- Fetches 1024-bit pixel rows from the input image RAM and builds a sliding 3-row window for the convolution core.
- Waits for the core's result, then writes each result row to the output RAM at a sequential address.
- Replaces the free-running 4-cycle write cadence with a handshake-driven FSM, and flags completion after the last valid output row.

Parameters:
ROWS, 128, number of input image rows; must be >= 3 and <= 2**ADDR_W
ADDR_W, 8, RAM address width
DATA_W, 1024, row width in bits
RD_LAT, 1, input RAM read latency in cycles; must be >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle pulse that begins a pass; ignored while busy=1
in_rd_en  output  1  input RAM read strobe
in_addr  output  ADDR_W  input RAM read address
in_data  input  DATA_W  input RAM read data, valid RD_LAT cycles after in_rd_en
win_row0  output  DATA_W  oldest window row
win_row1  output  DATA_W  middle window row
win_row2  output  DATA_W  newest window row
win_valid  output  1  window valid, one-cycle pulse
conv_valid  input  1  convolution result valid
conv_data  input  DATA_W  convolution result row
out_we  output  1  output RAM write enable
out_addr  output  ADDR_W  output RAM write address
out_data  output  DATA_W  output RAM write data
busy  output  1  pass in progress
done  output  1  pass complete, sticky

Behaviour:
- Reset (synchronous, sampled on clk edge, overrides everything including start): state=IDLE.
  - rd_ptr=0, wr_ptr=0, fill=0.
  - All outputs 0, including window rows, out_data, done and busy.
- States: IDLE, FETCH, CAPTURE, ISSUE, WAIT, WRITE, DONE.
- IDLE and DONE: start=1 moves to FETCH; clears rd_ptr, wr_ptr, fill and done; sets busy=1.
- FETCH: in_rd_en=1 and in_addr=rd_ptr for exactly one cycle, then CAPTURE.
- CAPTURE: lasts RD_LAT cycles. On its last cycle:
  - Shift the window: row0<=row1, row1<=row2, row2<=in_data.
  - rd_ptr+=1; fill saturates at 3.
  - Next state: FETCH if the new fill < 3, else ISSUE.
- ISSUE: win_valid=1 for one cycle, then WAIT. win_row* are held stable from ISSUE through WRITE.
- WAIT: holds indefinitely until conv_valid=1. On that cycle, conv_data is latched into out_data and the FSM moves to WRITE.
  - conv_valid in any other state is ignored.
  - There is no timeout.
- WRITE: out_we=1 and out_addr=wr_ptr for exactly one cycle; out_data is the latched result; wr_ptr+=1.
  - If the address just written is ROWS-3: go to DONE, busy=0, done=1 from the next cycle.
  - Otherwise go to FETCH; the next window reuses two buffered rows plus one new fetch.
- Output rows per pass = ROWS-2, at addresses 0..ROWS-3. Input reads cover addresses 0..ROWS-1, each read exactly once.
- Default minimum latency: start to first win_valid is 7 cycles. The steady-state row period is 4+RD_LAT cycles when conv_valid arrives in the first WAIT cycle.
- in_rd_en, win_valid and out_we are mutually exclusive and never asserted in IDLE or DONE.
- rd_ptr and wr_ptr never exceed ROWS. No wrap-around occurs within a pass.
- Reset mid-pass aborts immediately to the reset state. No further reads or writes are issued.

Test Plan:
1. Default params; reset, start pulse at cycle 0, conv_valid=1 in the first WAIT cycle with conv_data = row index -> in_rd_en at cycles 1, 3, 5; win_valid at 7; out_we at 9 with addr 0; 126 writes at addr 0..125; done=1 and busy=0 after the write of addr 125; in_addr never reaches 128.
2. Window contents: RAM row k = k replicated -> window m presents rows m, m+1, m+2 on win_row0/1/2 when win_valid pulses.
3. conv_valid delayed 10 cycles in WAIT, plus spurious conv_valid pulses during FETCH/ISSUE -> spurious pulses ignored; exactly one out_we per window; out_data equals the conv_data sampled in WAIT.
4. start pulsed while busy, and again after done -> ignored while busy; after done it restarts cleanly (done clears, addresses restart at 0).
5. Reset asserted during WAIT at window 40 -> the next cycle shows all outputs 0 and state IDLE; no out_we follows; a new start runs a full 126-row pass.
6. ROWS=3, RD_LAT=2 -> three reads each separated by a 2-cycle CAPTURE, one win_valid, one write at addr 0, then done=1.
